vaccine_spawn_generator: RTL and testbench

Pseudo-random spawn source for the vaccine field. It holds an always-in-range candidate position (`randX`, `randY`) and a visibility mask (`rand_draw_request`) that the vaccine position/collision stage samples when a vaccine is collected. After each collection event it searches for a fresh candidate by LFSR rejection sampling, so the outputs never present out-of-frame coordinates or an empty mask.

---
 rtl/vaccine_spawn_generator.sv | 200 ++++++++++++++++++++
 tb/tb_vaccine_spawn_generator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vaccine_spawn_generator.sv
// Pseudo-random vaccine spawn source: free-running LFSRs feed a rejection-sampling
// search whose result (position + visibility mask) is committed atomically.
module vaccine_spawn_generator #(
  parameter int unsigned X_MIN      = 16,
  parameter int unsigned X_MAX      = 575,
  parameter int unsigned Y_MIN      = 96,
  parameter int unsigned Y_MAX      = 415,
  parameter int unsigned MIN_ACTIVE = 4,
  parameter int unsigned MAX_TRIES  = 32,
  parameter logic [15:0] SEED_X     = 16'hACE1,
  parameter logic [14:0] SEED_Y     = 15'h1D2B,
  parameter logic [9:0]  SEED_M     = 10'h2B5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        collision,
  input  logic        regen,
  output logic [10:0] randX,
  output logic [10:0] randY,
  output logic [9:0]  rand_draw_request,
  output logic        rand_valid
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 2);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] TRY_ZERO = {TRY_W{1'b0}};
  localparam logic [TRY_W-1:0] TRY_ONE  = {{(TRY_W-1){1'b0}}, 1'b1};
  localparam logic [10:0] X_RST = 11'(X_MIN);
  localparam logic [10:0] Y_RST = 11'(Y_MIN);
  localparam logic [3:0]  MIN_ACT = 4'(MIN_ACTIVE);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEARCH_X = 2'd1,
    ST_SEARCH_Y = 2'd2,
    ST_SEARCH_M = 2'd3
  } state_e;

  function automatic logic [15:0] lfsr_x_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [14:0] lfsr_y_step(input logic [14:0] v);
    return {1'b0, v[14:1]} ^ (v[0] ? 15'h6000 : 15'h0000);
  endfunction

  function automatic logic [9:0] lfsr_m_step(input logic [9:0] v);
    return {1'b0, v[9:1]} ^ (v[0] ? 10'h240 : 10'h000);
  endfunction

  function automatic logic [3:0] popcount10(input logic [9:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 10; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [TRY_W-1:0] try_q, try_d, try_inc_s;
  logic             pending_q, pending_d;
  logic             col_d_q;
  logic [15:0]      lfsr_x_q;
  logic [14:0]      lfsr_y_q;
  logic [9:0]       lfsr_m_q;
  logic [10:0]      nx_q, nx_d, ny_q, ny_d;
  logic [10:0]      randx_q, randx_d, randy_q, randy_d;
  logic [9:0]       mask_q, mask_d;
  logic             valid_q, valid_d;

  logic [10:0] cx_s, cy_s;
  logic        x_ok_s, y_ok_s, m_ok_s, trig_s, try_last_s;

  assign cx_s       = {1'b0, lfsr_x_q[9:0]};
  assign cy_s       = {2'b00, lfsr_y_q[8:0]};
  assign x_ok_s     = (32'(cx_s) >= X_MIN) && (32'(cx_s) <= X_MAX);
  assign y_ok_s     = (32'(cy_s) >= Y_MIN) && (32'(cy_s) <= Y_MAX);
  assign m_ok_s     = popcount10(lfsr_m_q) >= MIN_ACT;
  assign trig_s     = (collision & ~col_d_q) | regen;
  assign try_last_s = (try_q == TRY_LAST);

  // Free-running sources and the collision edge detector, independent of the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_x_q <= SEED_X;
      lfsr_y_q <= SEED_Y;
      lfsr_m_q <= SEED_M;
      col_d_q  <= 1'b0;
    end else begin
      lfsr_x_q <= lfsr_x_step(lfsr_x_q);
      lfsr_y_q <= lfsr_y_step(lfsr_y_q);
      lfsr_m_q <= lfsr_m_step(lfsr_m_q);
      col_d_q  <= collision;
    end
  end

  // Search FSM state, scratch candidate and committed outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SEARCH_X;
      try_q     <= TRY_ZERO;
      pending_q <= 1'b0;
      nx_q      <= X_RST;
      ny_q      <= Y_RST;
      randx_q   <= X_RST;
      randy_q   <= Y_RST;
      mask_q    <= 10'h3FF;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      try_q     <= try_d;
      pending_q <= pending_d;
      nx_q      <= nx_d;
      ny_q      <= ny_d;
      randx_q   <= randx_d;
      randy_q   <= randy_d;
      mask_q    <= mask_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state: each search state either accepts, falls back on the last try, or retries.
  always_comb begin
    state_d   = state_q;
    try_inc_s = try_q;
    nx_d      = nx_q;
    ny_d      = ny_q;
    randx_d   = randx_q;
    randy_d   = randy_q;
    mask_d    = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (trig_s) begin
          state_d = ST_SEARCH_X;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEARCH_X: begin
        if (x_ok_s) begin
          nx_d    = cx_s;
          state_d = ST_SEARCH_Y;
        end else if (try_last_s) begin
          nx_d    = randx_q;
          state_d = ST_SEARCH_Y;
        end else begin
          try_inc_s = try_q + TRY_ONE;
        end
      end
      ST_SEARCH_Y: begin
        if (y_ok_s) begin
          ny_d    = cy_s;
          state_d = ST_SEARCH_M;
        end else if (try_last_s) begin
          ny_d    = randy_q;
          state_d = ST_SEARCH_M;
        end else begin
          try_inc_s = try_q + TRY_ONE;
        end
      end
      ST_SEARCH_M: begin
        if (m_ok_s || try_last_s) begin
          randx_d = nx_q;
          randy_d = ny_q;
          mask_d  = m_ok_s ? lfsr_m_q : mask_q;
          if (pending_q || trig_s) begin
            state_d = ST_SEARCH_X;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          try_inc_s = try_q + TRY_ONE;
        end
      end
      default: begin
        state_d = ST_SEARCH_X;
      end
    endcase

    try_d = (state_d != state_q) ? TRY_ZERO : try_inc_s;

    // At most one request is remembered; it is consumed by the next entry to SEARCH_X.
    if ((state_d == ST_SEARCH_X) && (state_q != ST_SEARCH_X)) begin
      pending_d = 1'b0;
    end else if (trig_s && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    valid_d = (state_d == ST_IDLE);
  end

  assign randX             = randx_q;
  assign randY             = randy_q;
  assign rand_draw_request = mask_q;
  assign rand_valid        = valid_q;

endmodule

// File: tb/tb_vaccine_spawn_generator.sv
// Scoreboarded random test of vaccine_spawn_generator with three parameterisations
// (default, unsatisfiable X with short fallback, all-accept) checked against a search model.
module tb_vaccine_spawn_generator;

  localparam int ND   = 3;
  localparam int MAXC = 3200;
  localparam int P_XMIN [ND] = '{16, 600, 0};
  localparam int P_XMAX [ND] = '{575, 500, 1023};
  localparam int P_YMIN [ND] = '{96, 96, 0};
  localparam int P_YMAX [ND] = '{415, 415, 511};
  localparam int P_MINA [ND] = '{4, 4, 1};
  localparam int P_TRY  [ND] = '{32, 8, 32};

  typedef struct {
    int cyc;
    int x;
    int y;
    int m;
  } rec_t;

  logic        clk;
  logic        reset;
  logic        collision;
  logic        regen;
  logic [10:0] rx [ND];
  logic [10:0] ry [ND];
  logic [9:0]  rm [ND];
  logic        rv [ND];

  int n_chk;
  int n_fail;
  int cyc;
  bit mon_en;
  int mstart0;

  logic [15:0] lx [MAXC];
  logic [14:0] ly [MAXC];
  logic [9:0]  lm [MAXC];
  bit          col [MAXC];
  bit          rg [MAXC];
  bit          trig [MAXC];
  bit          ev [ND][MAXC];
  rec_t        sbq [ND][$];
  rec_t        cur [ND];

  vaccine_spawn_generator u_dut0 (
    .clk(clk), .reset(reset), .collision(collision), .regen(regen),
    .randX(rx[0]), .randY(ry[0]), .rand_draw_request(rm[0]), .rand_valid(rv[0])
  );

  vaccine_spawn_generator #(.X_MIN(600), .X_MAX(500), .MAX_TRIES(8)) u_dut1 (
    .clk(clk), .reset(reset), .collision(collision), .regen(regen),
    .randX(rx[1]), .randY(ry[1]), .rand_draw_request(rm[1]), .rand_valid(rv[1])
  );

  vaccine_spawn_generator #(.X_MIN(0), .X_MAX(1023), .Y_MIN(0), .Y_MAX(511),
                            .MIN_ACTIVE(1)) u_dut2 (
    .clk(clk), .reset(reset), .collision(collision), .regen(regen),
    .randX(rx[2]), .randY(ry[2]), .rand_draw_request(rm[2]), .rand_valid(rv[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc, act, exp);
    end
  endtask

  function automatic bit x_ok(input int d, input logic [15:0] v);
    int c;
    c = int'(v[9:0]);
    return (c >= P_XMIN[d]) && (c <= P_XMAX[d]);
  endfunction

  function automatic bit y_ok(input int d, input logic [14:0] v);
    int c;
    c = int'(v[8:0]);
    return (c >= P_YMIN[d]) && (c <= P_YMAX[d]);
  endfunction

  function automatic bit m_ok(input int d, input logic [9:0] v);
    return $countones(v) >= P_MINA[d];
  endfunction

  // LFSR contents for every cycle after reset release (cycle 0 holds the seeds).
  task automatic build_lfsr();
    lx[0] = 16'hACE1;
    ly[0] = 15'h1D2B;
    lm[0] = 10'h2B5;
    for (int n = 1; n < MAXC; n++) begin
      lx[n] = lx[n-1][0] ? ((lx[n-1] >> 1) ^ 16'hB400) : (lx[n-1] >> 1);
      ly[n] = ly[n-1][0] ? ((ly[n-1] >> 1) ^ 15'h6000) : (ly[n-1] >> 1);
      lm[n] = lm[n-1][0] ? ((lm[n-1] >> 1) ^ 10'h240) : (lm[n-1] >> 1);
    end
  endtask

  task automatic gen_stim(input int ncyc, input int p_col, input int p_rg);
    bit c;
    c = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      if (p_col > 0 && $urandom_range(p_col - 1) == 0) c = !c;
      col[n] = c;
      rg[n]  = (p_rg > 0) && ($urandom_range(p_rg - 1) == 0);
      trig[n] = (col[n] && !((n > 0) ? col[n-1] : 1'b0)) || rg[n];
    end
  endtask

  // Timeline model: search start, per-field decision cycles, commit, then IDLE or chained search.
  task automatic build_model(input int d, input int ncyc);
    int s, t, u, e, ox, oy, om, nx, ny, nm;
    bit pend;
    rec_t r;
    ox = P_XMIN[d];
    oy = P_YMIN[d];
    om = 10'h3FF;
    for (int n = 0; n < MAXC; n++) ev[d][n] = 1'b0;
    s = 0;
    while (s < ncyc) begin
      t = s;
      while (t < ncyc && !x_ok(d, lx[t]) && (t - s) < P_TRY[d]) t++;
      if (t >= ncyc) break;
      nx = x_ok(d, lx[t]) ? int'(lx[t][9:0]) : ox;
      t++;
      u = t;
      while (t < ncyc && !y_ok(d, ly[t]) && (t - u) < P_TRY[d]) t++;
      if (t >= ncyc) break;
      ny = y_ok(d, ly[t]) ? int'(ly[t][8:0]) : oy;
      t++;
      u = t;
      if (d == 0 && mstart0 < 0) mstart0 = u;
      while (t < ncyc && !m_ok(d, lm[t]) && (t - u) < P_TRY[d]) t++;
      if (t >= ncyc) break;
      nm = m_ok(d, lm[t]) ? int'(lm[t]) : om;
      e = t;
      ox = nx; oy = ny; om = nm;
      r.cyc = e + 1; r.x = nx; r.y = ny; r.m = nm;
      sbq[d].push_back(r);
      pend = 1'b0;
      for (int n = s; n <= e; n++) if (trig[n]) pend = 1'b1;
      if (pend) begin
        s = e + 1;
      end else begin
        t = e + 1;
        while (t < ncyc && !trig[t]) begin
          ev[d][t] = 1'b1;
          t++;
        end
        if (t < ncyc) ev[d][t] = 1'b1;
        s = t + 1;
      end
    end
  endtask

  task automatic check_reset_vals();
    for (int d = 0; d < ND; d++) begin
      chk("reset_randX", d, int'(rx[d]), P_XMIN[d]);
      chk("reset_randY", d, int'(ry[d]), P_YMIN[d]);
      chk("reset_mask", d, int'(rm[d]), 10'h3FF);
      chk("reset_valid", d, int'(rv[d]), 0);
    end
  endtask

  // One reset-to-reset phase; with abort set it ends by resetting inside the first SEARCH_M.
  task automatic run_phase(input int ncyc_in, input int p_col, input int p_rg, input bit abort);
    int ncyc;
    ncyc = ncyc_in;
    gen_stim(ncyc, p_col, p_rg);
    if (abort) begin
      mstart0 = -1;
      build_model(0, ncyc);
      ncyc = (mstart0 > 0) ? mstart0 : 4;
      sbq[0].delete();
    end
    mstart0 = -1;
    for (int d = 0; d < ND; d++) begin
      build_model(d, ncyc);
      cur[d].cyc = 0; cur[d].x = P_XMIN[d]; cur[d].y = P_YMIN[d]; cur[d].m = 10'h3FF;
    end
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    collision = col[0];
    regen = rg[0];
    mon_en = 1'b1;
    for (int n = 1; n < ncyc; n++) begin
      @(negedge clk);
      cyc = n;
      collision = col[n];
      regen = rg[n];
    end
    @(negedge clk);
    mon_en = 1'b0;
    reset = 1'b1;
    cyc = ncyc;
    collision = 1'b0;
    regen = 1'b0;
    #1;
    check_reset_vals();
    for (int d = 0; d < ND; d++) begin
      while (sbq[d].size() > 0) begin
        if (sbq[d][0].cyc < ncyc) chk("commit_seen", d, 0, 1);
        void'(sbq[d].pop_front());
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: retires due commits from the scoreboard and compares every cycle.
  always begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      for (int d = 0; d < ND; d++) begin
        if (sbq[d].size() > 0 && sbq[d][0].cyc == cyc) begin
          cur[d] = sbq[d].pop_front();
          if (d == 0) begin
            chk("x_in_range", d, int'(rx[d] >= 11'd16 && rx[d] <= 11'd575), 1);
            chk("y_in_range", d, int'(ry[d] >= 11'd96 && ry[d] <= 11'd415), 1);
            chk("mask_popcount", d, int'($countones(rm[d]) >= 4), 1);
          end
        end
        chk("randX", d, int'(rx[d]), cur[d].x);
        chk("randY", d, int'(ry[d]), cur[d].y);
        chk("mask", d, int'(rm[d]), cur[d].m);
        chk("rand_valid", d, int'(rv[d]), int'(ev[d][cyc]));
      end
    end
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    mon_en = 1'b0;
    mstart0 = -1;
    reset = 1'b1;
    collision = 1'b0;
    regen = 1'b0;
    build_lfsr();
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals();
    run_phase(3000, 150, 200, 1'b0);
    run_phase(1500, 6, 10, 1'b0);
    run_phase(1500, 60, 0, 1'b0);
    run_phase(200, 0, 0, 1'b1);
    run_phase(400, 0, 25, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
